// File: rtl/riscv_hazard_sb.sv
// Hazard unit for the 5-stage RV32 pipeline with a pending-write scoreboard
// for the out-of-pipeline long-latency unit (mul/div). Drives every stage
// stall, flush and forward-select control; all controls are combinational
// from the inputs and the registered scoreboard state.
module riscv_hazard_sb #(
  parameter int REG_AW = 5,
  parameter int LU_MAX = 2,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // decode stage
  input  logic [REG_AW-1:0] i_rs_1d,
  input  logic [REG_AW-1:0] i_rs_2d,
  input  logic [REG_AW-1:0] i_rd_d,
  input  logic              i_long_d,
  // execute stage
  input  logic [REG_AW-1:0] i_rs_1e,
  input  logic [REG_AW-1:0] i_rs_2e,
  input  logic [REG_AW-1:0] i_rd_e,
  input  logic              i_reg_write_e,
  input  logic              i_load_e,
  input  logic              i_long_e,
  input  logic [1:0]        i_pc_src_e,
  // memory / writeback stages
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic              i_reg_write_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_write_w,
  input  logic              i_dmem_wait,
  // long-unit writeback
  input  logic              i_lu_done,
  input  logic [REG_AW-1:0] i_lu_rd,
  // controls
  output logic              o_stall_f,
  output logic              o_stall_d,
  output logic              o_stall_e,
  output logic              o_stall_m,
  output logic              o_flush_d,
  output logic              o_flush_e,
  output logic              o_flush_w,
  output logic [1:0]        o_forward_ae,
  output logic [1:0]        o_forward_be,
  output logic              o_lu_busy,
  output logic              o_lu_full
);

  localparam int         NREG     = 1 << REG_AW;
  localparam logic [2:0] LU_MAX_C = 3'(LU_MAX);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // scoreboard state: one pending bit per architectural register + op count
  logic [NREG-1:0] pend_q, pend_d;
  logic [2:0]      cnt_q, cnt_d;

  logic haz;
  logic ld_use, long_in_e, sb_raw, sb_waw, lu_struct, no_fwd_raw;
  logic lu_full_w;
  logic issue;

  // a producer matches a consumer only when it writes a real register (x0 never matches)
  function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

  assign lu_full_w = (cnt_q == LU_MAX_C);

  // E-stage operand forwarding: M is younger than W, so it wins
  always_comb begin
    o_forward_ae = FWD_RF;
    o_forward_be = FWD_RF;
    if (FWD_EN) begin
      if (hit(i_reg_write_m, i_rd_m, i_rs_1e))      o_forward_ae = FWD_M;
      else if (hit(i_reg_write_w, i_rd_w, i_rs_1e)) o_forward_ae = FWD_W;
      if (hit(i_reg_write_m, i_rd_m, i_rs_2e))      o_forward_be = FWD_M;
      else if (hit(i_reg_write_w, i_rd_w, i_rs_2e)) o_forward_be = FWD_W;
    end
  end

  // hazard detection in D; the long op sitting in E is not yet in the scoreboard,
  // so it is caught by its own term rather than through pend
  always_comb begin
    ld_use     = i_load_e && (hit(1'b1, i_rd_e, i_rs_1d) || hit(1'b1, i_rd_e, i_rs_2d));
    long_in_e  = i_long_e && (hit(1'b1, i_rd_e, i_rs_1d) || hit(1'b1, i_rd_e, i_rs_2d));
    sb_raw     = pend_q[i_rs_1d] || pend_q[i_rs_2d];
    sb_waw     = i_long_d && pend_q[i_rd_d];
    lu_struct  = i_long_d && lu_full_w;
    no_fwd_raw = 1'b0;
    if (!FWD_EN) begin
      no_fwd_raw = hit(i_reg_write_e, i_rd_e, i_rs_1d) || hit(i_reg_write_e, i_rd_e, i_rs_2d) ||
                   hit(i_reg_write_m, i_rd_m, i_rs_1d) || hit(i_reg_write_m, i_rd_m, i_rs_2d) ||
                   hit(i_reg_write_w, i_rd_w, i_rs_1d) || hit(i_reg_write_w, i_rd_w, i_rs_2d);
    end
    haz = ld_use || long_in_e || sb_raw || sb_waw || lu_struct || no_fwd_raw;
  end

  // control priority: memory freeze, then redirect, then D-stage hazard
  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_stall_m = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_w = 1'b0;
    if (i_dmem_wait) begin
      // whole front of the pipe holds; W is bubbled so nothing retires twice
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_stall_e = 1'b1;
      o_stall_m = 1'b1;
      o_flush_w = 1'b1;
    end else if (i_pc_src_e != 2'b00) begin
      // wrong-path instructions in D and E are squashed; any hazard they had is moot
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
    end else if (haz) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_flush_e = 1'b1;
    end
  end

  // a long op leaves E into the unit only when E is not frozen
  assign issue = i_long_e && !o_stall_e;

  // scoreboard next state: clear on writeback, then set on issue so set wins
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (i_lu_done) pend_d[i_lu_rd] = 1'b0;
    if (issue && i_reg_write_e && (i_rd_e != '0)) pend_d[i_rd_e] = 1'b1;
    pend_d[0] = 1'b0;
    if (issue && !i_lu_done) begin
      if (!lu_full_w) cnt_d = cnt_q + 3'd1;
    end else if (i_lu_done && !issue) begin
      if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
    end
  end

  // scoreboard registers; reset may land mid-stall and drops everything outstanding
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q <= '0;
      cnt_q  <= 3'd0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_lu_busy = (cnt_q != 3'd0);
  assign o_lu_full = lu_full_w;

endmodule

// File: tb/tb_riscv_hazard_sb.sv
// Directed bench for riscv_hazard_sb: forwarding, load-use, redirect,
// scoreboard RAW/WAW, structural limit, dmem freeze and async reset.
module tb_riscv_hazard_sb;

  localparam int AW = 5;

  // packed control view: {sf,sd,se,sm,fd,fe,fw,ae[1:0],be[1:0],busy,full}
  localparam logic [12:0] NONE = 13'b0000000_000000;
  localparam logic [12:0] HAZ  = 13'b1100010_000000;
  localparam logic [12:0] RED  = 13'b0000110_000000;
  localparam logic [12:0] DMW  = 13'b1111001_000000;
  localparam logic [12:0] BUSY = 13'b0000000_000010;
  localparam logic [12:0] FULL = 13'b0000000_000011;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] rs_1d, rs_2d, rd_d, rs_1e, rs_2e, rd_e, rd_m, rd_w, lu_rd;
  logic long_d, wr_e, load_e, long_e, wr_m, wr_w, dmem_wait, lu_done;
  logic [1:0] pc_src_e;

  logic sf, sd, se, sm, fd, fe, fw, busy, full;
  logic [1:0] fae, fbe;
  logic sf_n, sd_n, se_n, sm_n, fd_n, fe_n, fw_n, busy_n, full_n;
  logic [1:0] fae_n, fbe_n;
  logic [12:0] ctl, ctl_n;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_hazard_sb #(.REG_AW(AW), .LU_MAX(2), .FWD_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_rs_1d(rs_1d), .i_rs_2d(rs_2d), .i_rd_d(rd_d), .i_long_d(long_d),
    .i_rs_1e(rs_1e), .i_rs_2e(rs_2e), .i_rd_e(rd_e),
    .i_reg_write_e(wr_e), .i_load_e(load_e), .i_long_e(long_e), .i_pc_src_e(pc_src_e),
    .i_rd_m(rd_m), .i_reg_write_m(wr_m), .i_rd_w(rd_w), .i_reg_write_w(wr_w),
    .i_dmem_wait(dmem_wait), .i_lu_done(lu_done), .i_lu_rd(lu_rd),
    .o_stall_f(sf), .o_stall_d(sd), .o_stall_e(se), .o_stall_m(sm),
    .o_flush_d(fd), .o_flush_e(fe), .o_flush_w(fw),
    .o_forward_ae(fae), .o_forward_be(fbe), .o_lu_busy(busy), .o_lu_full(full)
  );

  riscv_hazard_sb #(.REG_AW(AW), .LU_MAX(2), .FWD_EN(1'b0)) u_nf (
    .i_clk(clk), .i_rst(rst),
    .i_rs_1d(rs_1d), .i_rs_2d(rs_2d), .i_rd_d(rd_d), .i_long_d(long_d),
    .i_rs_1e(rs_1e), .i_rs_2e(rs_2e), .i_rd_e(rd_e),
    .i_reg_write_e(wr_e), .i_load_e(load_e), .i_long_e(long_e), .i_pc_src_e(pc_src_e),
    .i_rd_m(rd_m), .i_reg_write_m(wr_m), .i_rd_w(rd_w), .i_reg_write_w(wr_w),
    .i_dmem_wait(dmem_wait), .i_lu_done(lu_done), .i_lu_rd(lu_rd),
    .o_stall_f(sf_n), .o_stall_d(sd_n), .o_stall_e(se_n), .o_stall_m(sm_n),
    .o_flush_d(fd_n), .o_flush_e(fe_n), .o_flush_w(fw_n),
    .o_forward_ae(fae_n), .o_forward_be(fbe_n), .o_lu_busy(busy_n), .o_lu_full(full_n)
  );

  assign ctl   = {sf, sd, se, sm, fd, fe, fw, fae, fbe, busy, full};
  assign ctl_n = {sf_n, sd_n, se_n, sm_n, fd_n, fe_n, fw_n, fae_n, fbe_n, busy_n, full_n};

  task automatic clr;
    rs_1d = '0; rs_2d = '0; rd_d = '0; long_d = 1'b0;
    rs_1e = '0; rs_2e = '0; rd_e = '0; wr_e = 1'b0; load_e = 1'b0; long_e = 1'b0;
    pc_src_e = 2'b00; rd_m = '0; wr_m = 1'b0; rd_w = '0; wr_w = 1'b0;
    dmem_wait = 1'b0; lu_done = 1'b0; lu_rd = '0;
  endtask

  // advance one edge; inputs are then driven 1 time unit after it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr();
    rst = 1'b1;
    tick(); tick();
    #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL reset_in got %b exp %b", ctl, NONE); end
    rst = 1'b0;
    tick(); #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL reset_out got %b exp %b", ctl, NONE); end
    n_chk++; if (ctl_n !== NONE) begin n_fail++; $display("FAIL reset_nf got %b exp %b", ctl_n, NONE); end
  endtask

  task automatic test_forward;
    clr();
    rd_m = 5'd5; wr_m = 1'b1; rd_w = 5'd5; wr_w = 1'b1; rs_1e = 5'd5; rs_2e = 5'd5; #1;
    n_chk++; if (fae !== 2'b10) begin n_fail++; $display("FAIL fwd_m_prio got %b exp 10", fae); end
    n_chk++; if (fbe !== 2'b10) begin n_fail++; $display("FAIL fwd_m_prio_b got %b exp 10", fbe); end
    n_chk++; if (fae_n !== 2'b00) begin n_fail++; $display("FAIL fwd_nf got %b exp 00", fae_n); end
    wr_m = 1'b0; #1;
    n_chk++; if (fae !== 2'b01) begin n_fail++; $display("FAIL fwd_w got %b exp 01", fae); end
    rs_2e = 5'd6; #1;
    n_chk++; if (fbe !== 2'b00) begin n_fail++; $display("FAIL fwd_nomatch got %b exp 00", fbe); end
    wr_m = 1'b1; rd_m = 5'd0; rd_w = 5'd0; rs_1e = 5'd0; #1;
    n_chk++; if (fae !== 2'b00) begin n_fail++; $display("FAIL fwd_x0 got %b exp 00", fae); end
    clr();
    rs_1d = 5'd5; rd_e = 5'd5; wr_e = 1'b1; #1;
    n_chk++; if (ctl_n !== HAZ) begin n_fail++; $display("FAIL nofwd_e got %b exp %b", ctl_n, HAZ); end
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL fwd_e_nostall got %b exp %b", ctl, NONE); end
    clr();
    rs_2d = 5'd5; rd_w = 5'd5; wr_w = 1'b1; #1;
    n_chk++; if (ctl_n !== HAZ) begin n_fail++; $display("FAIL nofwd_w got %b exp %b", ctl_n, HAZ); end
    clr();
  endtask

  task automatic test_load_use;
    clr();
    load_e = 1'b1; rd_e = 5'd7; wr_e = 1'b1; rs_2d = 5'd7; #1;
    n_chk++; if (ctl !== HAZ) begin n_fail++; $display("FAIL load_use got %b exp %b", ctl, HAZ); end
    tick();
    // bubble now in E, load moved to M; forwarding covers it
    load_e = 1'b0; rd_e = 5'd0; wr_e = 1'b0; rd_m = 5'd7; wr_m = 1'b1; #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL load_use_one got %b exp %b", ctl, NONE); end
    clr();
    load_e = 1'b1; rd_e = 5'd7; wr_e = 1'b1; rs_2d = 5'd7; pc_src_e = 2'b01; #1;
    n_chk++; if (ctl !== RED) begin n_fail++; $display("FAIL redirect_wins got %b exp %b", ctl, RED); end
    load_e = 1'b0; rs_2d = 5'd0; pc_src_e = 2'b00; rs_1d = 5'd0; rd_e = 5'd0; #1;
    load_e = 1'b1; rd_e = 5'd0; rs_1d = 5'd0; #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL load_x0 got %b exp %b", ctl, NONE); end
    clr();
  endtask

  task automatic test_scoreboard;
    clr();
    long_e = 1'b1; rd_e = 5'd9; wr_e = 1'b1; rs_1d = 5'd9; #1;
    n_chk++; if (ctl !== HAZ) begin n_fail++; $display("FAIL long_in_e got %b exp %b", ctl, HAZ); end
    tick();
    long_e = 1'b0; rd_e = 5'd0; wr_e = 1'b0; #1;
    n_chk++; if (ctl !== (HAZ | BUSY)) begin n_fail++; $display("FAIL sb_raw got %b exp %b", ctl, HAZ | BUSY); end
    tick(); #1;
    n_chk++; if (ctl !== (HAZ | BUSY)) begin n_fail++; $display("FAIL sb_raw_hold got %b exp %b", ctl, HAZ | BUSY); end
    lu_done = 1'b1; lu_rd = 5'd9; #1;
    n_chk++; if (ctl !== (HAZ | BUSY)) begin n_fail++; $display("FAIL sb_done_cycle got %b exp %b", ctl, HAZ | BUSY); end
    tick();
    lu_done = 1'b0; lu_rd = 5'd0; #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL sb_release got %b exp %b", ctl, NONE); end
    clr();
  endtask

  task automatic test_structural;
    clr();
    long_e = 1'b1; rd_e = 5'd9; wr_e = 1'b1;
    tick();
    rd_e = 5'd10; #1;
    n_chk++; if (ctl !== BUSY) begin n_fail++; $display("FAIL lu_one got %b exp %b", ctl, BUSY); end
    tick();
    long_e = 1'b0; rd_e = 5'd0; wr_e = 1'b0; #1;
    n_chk++; if (ctl !== FULL) begin n_fail++; $display("FAIL lu_full got %b exp %b", ctl, FULL); end
    long_d = 1'b1; rd_d = 5'd11; #1;
    n_chk++; if (ctl !== (HAZ | FULL)) begin n_fail++; $display("FAIL lu_struct got %b exp %b", ctl, HAZ | FULL); end
    long_d = 1'b0; rd_d = 5'd0;
    long_e = 1'b1; rd_e = 5'd11; wr_e = 1'b1; lu_done = 1'b1; lu_rd = 5'd9;
    tick();
    clr(); #1;
    n_chk++; if (ctl !== FULL) begin n_fail++; $display("FAIL done_issue_cnt got %b exp %b", ctl, FULL); end
    rs_1d = 5'd11; #1;
    n_chk++; if (ctl !== (HAZ | FULL)) begin n_fail++; $display("FAIL pend11_set got %b exp %b", ctl, HAZ | FULL); end
    rs_1d = 5'd9; #1;
    n_chk++; if (ctl !== FULL) begin n_fail++; $display("FAIL pend9_clr got %b exp %b", ctl, FULL); end
    clr();
  endtask

  task automatic test_dmem;
    // entry state: cnt=2, pend {10,11}
    clr();
    dmem_wait = 1'b1; long_e = 1'b1; rd_e = 5'd12; wr_e = 1'b1; lu_done = 1'b1; lu_rd = 5'd10; #1;
    n_chk++; if (ctl !== (DMW | FULL)) begin n_fail++; $display("FAIL dmem_freeze got %b exp %b", ctl, DMW | FULL); end
    tick();
    clr(); #1;
    n_chk++; if (ctl !== BUSY) begin n_fail++; $display("FAIL dmem_cnt got %b exp %b", ctl, BUSY); end
    rs_1d = 5'd12; #1;
    n_chk++; if (ctl !== BUSY) begin n_fail++; $display("FAIL dmem_noissue got %b exp %b", ctl, BUSY); end
    rs_1d = 5'd10; #1;
    n_chk++; if (ctl !== BUSY) begin n_fail++; $display("FAIL dmem_done_clr got %b exp %b", ctl, BUSY); end
    rs_1d = 5'd0; long_d = 1'b1; rd_d = 5'd11; #1;
    n_chk++; if (ctl !== (HAZ | BUSY)) begin n_fail++; $display("FAIL sb_waw got %b exp %b", ctl, HAZ | BUSY); end
    clr();
  endtask

  task automatic test_async_reset;
    // entry state: cnt=1, pend {11}; issue rd=9 to fill up
    clr();
    long_e = 1'b1; rd_e = 5'd9; wr_e = 1'b1;
    tick();
    clr(); rs_1d = 5'd9; #1;
    n_chk++; if (ctl !== (HAZ | FULL)) begin n_fail++; $display("FAIL pre_reset got %b exp %b", ctl, HAZ | FULL); end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL async_reset got %b exp %b", ctl, NONE); end
    tick();
    rst = 1'b0;
    clr(); #1;
    n_chk++; if (ctl !== NONE) begin n_fail++; $display("FAIL post_reset got %b exp %b", ctl, NONE); end
  endtask

  initial begin
    rst = 1'b1;
    clr();
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_structural();
    test_dmem();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
